// File: rtl/mux_share_arbiter.sv
// -----------------------------------------------------------------------------
// mux_share_arbiter
//
// Two-requester round-robin arbiter that owns the select line of a shared 2:1
// datapath mux. Requester A is routed through mux input a (sel=0) and requester
// B through mux input b (sel=1). Grants are registered and mutually exclusive,
// and sel always routes the current owner.
//
// Optional feature (compile-time macro MUX_ARB_TIMEOUT_EN):
//   When defined, an owner that has held the port for MAX_HOLD consecutive
//   cycles while the other requester is waiting is forcibly switched over.
//   The cycle in which the new owner first holds the grant carries a one-cycle
//   revoke pulse. When undefined, ownership is unbounded and revoke is tied 0.
//
// Parameters
//   FIRST_PRIO  requester favoured on the first contention after reset (0=A, 1=B)
//   MAX_HOLD    max consecutive owned cycles before forced revoke (>=2)
//   CNT_W       hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk     in   rising-edge system clock
//   rst_n   in   asynchronous active-low reset
//   req_a   in   A requests the shared port (level, held until granted)
//   rel_a   in   A releases ownership (1-cycle pulse, honoured only while gnt_a)
//   req_b   in   B request
//   rel_b   in   B release
//   gnt_a   out  A owns the port (registered)
//   gnt_b   out  B owns the port (registered)
//   sel     out  mux select: 0 routes a, 1 routes b (registered)
//   busy    out  gnt_a | gnt_b
//   revoke  out  1-cycle pulse when ownership was removed by timeout
// -----------------------------------------------------------------------------
module mux_share_arbiter #(
   parameter logic FIRST_PRIO = 1'b0,
   parameter int   MAX_HOLD   = 16,
   parameter int   CNT_W      = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic rel_a,
   input  logic req_b,
   input  logic rel_b,
   output logic gnt_a,
   output logic gnt_b,
   output logic sel,
   output logic busy,
   output logic revoke
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // last_owner encoding: 0 = A, 1 = B. Contention is awarded to the
   // requester that is not the last owner.
   logic last_owner;
   logic last_owner_nxt;

   // sel is held in its own register because it must keep its last value
   // while the arbiter is idle, which the state alone cannot express.
   logic sel_q;
   logic sel_nxt;

`ifdef MUX_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] hold_cnt;
   logic             hold_expired;
   logic             force_xfer;
   logic             revoke_q;

   assign hold_expired = (hold_cnt == HOLD_LAST);

   // Hold counter: cleared whenever a new owner takes the port (including a
   // direct A<->B hand-over), counts each owned cycle, and saturates at
   // MAX_HOLD-1 so a late-arriving contender triggers the transfer at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if ((state_nxt != IDLE) && (state_nxt != state)) begin
         hold_cnt <= '0;
      end else if ((state != IDLE) && !hold_expired) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_owner <= ~FIRST_PRIO;
         sel_q      <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
         revoke_q   <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         sel_q      <= sel_nxt;
`ifdef MUX_ARB_TIMEOUT_EN
         revoke_q   <= force_xfer;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
`ifdef MUX_ARB_TIMEOUT_EN
      force_xfer     = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (req_a && !req_b) begin
               state_nxt = OWN_A;
            end else if (req_b && !req_a) begin
               state_nxt = OWN_B;
            end else if (req_a && req_b) begin
               state_nxt = last_owner ? OWN_A : OWN_B;
            end
         end

         OWN_A: begin
            // A dropped request counts as a release; release beats a
            // simultaneous re-request, so a waiting B always goes next.
            if (rel_a || !req_a) begin
               state_nxt      = req_b ? OWN_B : IDLE;
               last_owner_nxt = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            end else if (hold_expired && req_b) begin
               state_nxt      = OWN_B;
               last_owner_nxt = 1'b0;
               force_xfer     = 1'b1;
`endif
            end
         end

         OWN_B: begin
            if (rel_b || !req_b) begin
               state_nxt      = req_a ? OWN_A : IDLE;
               last_owner_nxt = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
            end else if (hold_expired && req_a) begin
               state_nxt      = OWN_A;
               last_owner_nxt = 1'b1;
               force_xfer     = 1'b1;
`endif
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // sel moves on the same edge as the grant it serves, holds in IDLE.
      sel_nxt = sel_q;
      if (state_nxt == OWN_A) begin
         sel_nxt = 1'b0;
      end else if (state_nxt == OWN_B) begin
         sel_nxt = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode (from registered state only)
   // ---------------------------------------------------------------------------
   always_comb begin
      gnt_a  = (state == OWN_A);
      gnt_b  = (state == OWN_B);
      busy   = gnt_a | gnt_b;
      sel    = sel_q;
`ifdef MUX_ARB_TIMEOUT_EN
      revoke = revoke_q;
`else
      revoke = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_share_arbiter
//
// Directed, table-driven bench for mux_share_arbiter (MAX_HOLD=4, CNT_W=3,
// FIRST_PRIO=0). Each table row gives the inputs applied for one clock edge and
// the outputs expected just after that edge. Hand-written sequences cover the
// reset-time state, an asynchronous reset in the middle of a grant, and the
// hold-counter saturation case. Expectations for the timeout rows depend on
// whether MUX_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux_share_arbiter;

   logic clk;
   logic rst_n;
   logic req_a, rel_a, req_b, rel_b;
   logic gnt_a, gnt_b, sel, busy, revoke;

   int n_checks;
   int n_fail;

   typedef struct {
      logic rst_n;
      logic req_a;
      logic rel_a;
      logic req_b;
      logic rel_b;
      logic gnt_a;
      logic gnt_b;
      logic sel;
      logic revoke;
   } vec_t;

   vec_t vecs[$];

   mux_share_arbiter #(
      .FIRST_PRIO (1'b0),
      .MAX_HOLD   (4),
      .CNT_W      (3)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_a  (req_a),
      .rel_a  (rel_a),
      .req_b  (req_b),
      .rel_b  (rel_b),
      .gnt_a  (gnt_a),
      .gnt_b  (gnt_b),
      .sel    (sel),
      .busy   (busy),
      .revoke (revoke)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic ga, input logic gb,
                            input logic s, input logic rv);
      check({tag, " gnt_a"},  gnt_a,  ga);
      check({tag, " gnt_b"},  gnt_b,  gb);
      check({tag, " sel"},    sel,    s);
      check({tag, " busy"},   busy,   ga | gb);
      check({tag, " revoke"}, revoke, rv);
   endtask

   function automatic void push(input logic r, input logic ra, input logic la,
                                input logic rb, input logic lb, input logic ga,
                                input logic gb, input logic s, input logic rv);
      vec_t v;
      v.rst_n = r;  v.req_a = ra; v.rel_a = la; v.req_b = rb; v.rel_b = lb;
      v.gnt_a = ga; v.gnt_b = gb; v.sel = s;    v.revoke = rv;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic r, input logic ra, input logic la,
                        input logic rb, input logic lb);
      @(negedge clk);
      rst_n = r; req_a = ra; rel_a = la; req_b = rb; rel_b = lb;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      //    rst ra la rb lb | ga gb sel rv
      push(1, 1, 0, 0, 0,   1, 0, 0, 0);  // 0  out of reset: A granted 1 cycle later
      push(1, 0, 0, 0, 0,   0, 0, 0, 0);  // 1  A drops -> IDLE
      push(0, 1, 0, 1, 0,   0, 0, 0, 0);  // 2  reset again, both requesting
      push(1, 1, 0, 1, 0,   1, 0, 0, 0);  // 3  first contention -> A (FIRST_PRIO=0)
      push(1, 1, 1, 1, 0,   0, 1, 1, 0);  // 4  rel_a with req_a: straight to B
      push(1, 1, 0, 1, 0,   0, 1, 1, 0);  // 5  B owned 2nd cycle
      push(1, 1, 0, 1, 0,   0, 1, 1, 0);  // 6  B owned 3rd cycle
      push(1, 1, 0, 1, 1,   1, 0, 0, 0);  // 7  B releases -> A
      push(1, 1, 0, 1, 0,   1, 0, 0, 0);  // 8
      push(1, 1, 0, 1, 0,   1, 0, 0, 0);  // 9
      push(1, 1, 1, 1, 0,   0, 1, 1, 0);  // 10 A releases -> B
      push(1, 0, 1, 1, 0,   0, 1, 1, 0);  // 11 stray rel_a while B owns
      push(1, 0, 0, 1, 0,   0, 1, 1, 0);  // 12
      push(1, 0, 0, 0, 0,   0, 0, 1, 0);  // 13 B drops request -> IDLE, sel holds 1
      push(1, 0, 0, 0, 0,   0, 0, 1, 0);  // 14 idle, sel still 1
      push(1, 1, 0, 0, 0,   1, 0, 0, 0);  // 15 A alone
      push(1, 1, 1, 0, 0,   0, 0, 0, 0);  // 16 A release + re-request, B idle -> IDLE
      push(1, 1, 0, 0, 0,   1, 0, 0, 0);  // 17 regrant A (ownership cycle 0)
      push(1, 1, 0, 1, 0,   1, 0, 0, 0);  // 18 B waits, A cycle 1
      push(1, 1, 0, 1, 0,   1, 0, 0, 0);  // 19 A cycle 2
      push(1, 1, 0, 1, 0,   1, 0, 0, 0);  // 20 A cycle 3 (4th owned cycle)
`ifdef MUX_ARB_TIMEOUT_EN
      push(1, 1, 0, 1, 0,   0, 1, 1, 1);  // 21 forced transfer with revoke
      push(1, 1, 0, 1, 0,   0, 1, 1, 0);  // 22 revoke was a single pulse
      push(1, 1, 0, 1, 0,   0, 1, 1, 0);  // 23
`else
      push(1, 1, 0, 1, 0,   1, 0, 0, 0);  // 21 no timeout: A keeps the port
      push(1, 1, 0, 1, 0,   1, 0, 0, 0);  // 22
      push(1, 1, 0, 1, 0,   1, 0, 0, 0);  // 23
`endif

      // Reset state, with req_a already asserted.
      rst_n = 1'b0; req_a = 1'b1; rel_a = 1'b0; req_b = 1'b0; rel_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].req_a, vecs[i].rel_a, vecs[i].req_b, vecs[i].rel_b);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].gnt_a, vecs[i].gnt_b,
                   vecs[i].sel, vecs[i].revoke);
      end

      // Reset asserted mid-grant drops the grant without waiting for a clock.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check_all("midrst_pre", 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all("midrst_async", 1'b0, 1'b0, 1'b0, 1'b0);

      // Uncontended ownership: counter saturates, late contender then wins at once.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_all("sat_grant", 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check_all($sformatf("sat_hold%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
`ifdef MUX_ARB_TIMEOUT_EN
      check_all("sat_xfer", 1'b0, 1'b1, 1'b1, 1'b1);
`else
      check_all("sat_xfer", 1'b1, 1'b0, 1'b0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
